sdec_rr_scheduler: RTL and testbench

//  Time-multiplexes one shared SDEC decrementer across NUM_CH countdown channels.

---
 rtl/sdec_rr_scheduler.sv | 93 +++++++++
 tb/tb_sdec_rr_scheduler.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sdec_rr_scheduler.sv
// rtl/sdec_rr_scheduler.sv - round-robin slot scheduler sharing one SDEC decrementer across NUM_CH countdown channels
// Optional feature macro: SDEC_SCHED_PREEMPT_EN (loads may restart an active channel)
module sdec_rr_scheduler #(
   parameter int DATAWIDTH = 32,
   parameter int NUM_CH    = 4,
   parameter int CHW       = 2
) (
   input  logic                        Clk,
   input  logic                        Rst,
   input  logic                        ld_valid,
   input  logic [CHW-1:0]              ld_ch,
   input  logic signed [DATAWIDTH-1:0] ld_val,
   output logic                        ld_ready,
   output logic signed [DATAWIDTH-1:0] dec_a,
   input  logic signed [DATAWIDTH-1:0] dec_d,
   output logic [NUM_CH-1:0]           busy,
   output logic [NUM_CH-1:0]           done,
   output logic [CHW-1:0]              cur_ch,
   output logic                        err
);
   typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

   state_t                      r_state, w_state_nxt;
   logic signed [DATAWIDTH-1:0] r_cnt [NUM_CH];
   logic [NUM_CH-1:0]           r_busy, r_done, w_busy_nxt, w_done_nxt;
   logic [CHW-1:0]              r_ptr, w_ptr_nxt;
   logic                        r_err;
   logic                        w_ld_acc, w_ld_pos, w_ld_zero, w_ld_neg;
   logic                        w_slot_wr, w_slot_fin;

`ifdef SDEC_SCHED_PREEMPT_EN
   assign ld_ready = ~Rst;
`else
   assign ld_ready = ~Rst & ~r_busy[ld_ch];
`endif

   assign w_ld_acc  = ld_valid & ld_ready;
   assign w_ld_neg  = w_ld_acc & ld_val[DATAWIDTH-1];
   assign w_ld_zero = w_ld_acc & (ld_val == '0);
   assign w_ld_pos  = w_ld_acc & ~ld_val[DATAWIDTH-1] & (ld_val != '0);

   // A load to the channel owning this slot wins; the decrement result is dropped.
   assign w_slot_wr  = (r_state == S_RUN) & r_busy[r_ptr] & ~(w_ld_acc & (ld_ch == r_ptr));
   assign w_slot_fin = w_slot_wr & (dec_d == '0);

   always_comb begin
      w_busy_nxt  = r_busy;
      w_done_nxt  = '0;
      w_state_nxt = r_state;
      w_ptr_nxt   = '0;
      if (w_slot_fin) begin
         w_busy_nxt[r_ptr] = 1'b0;
         w_done_nxt[r_ptr] = 1'b1;
      end
      if (w_ld_acc) begin
         w_busy_nxt[ld_ch] = w_ld_pos;
         if (w_ld_zero) w_done_nxt[ld_ch] = 1'b1;
      end
      case (r_state)
         S_IDLE: if (|w_busy_nxt) w_state_nxt = S_RUN;
         S_RUN: begin
            if (~|w_busy_nxt) w_state_nxt = S_IDLE;
            else              w_ptr_nxt   = r_ptr + CHW'(1);
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_state <= S_IDLE;
         r_busy  <= '0;
         r_done  <= '0;
         r_ptr   <= '0;
         r_err   <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) r_cnt[i] <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
         r_ptr   <= w_ptr_nxt;
         if (w_ld_neg)  r_err <= 1'b1;
         if (w_slot_wr) r_cnt[r_ptr] <= dec_d;
         if (w_ld_pos)  r_cnt[ld_ch] <= ld_val;
      end
   end

   assign dec_a  = r_cnt[r_ptr];
   assign busy   = r_busy;
   assign done   = r_done;
   assign cur_ch = r_ptr;
   assign err    = r_err;

endmodule

// File: tb/tb_sdec_rr_scheduler.sv
// tb/tb_sdec_rr_scheduler.sv - directed and randomized checks of sdec_rr_scheduler against a cycle reference model
module tb_sdec_rr_scheduler;
   localparam int NUM_CH = 4;

   logic              Clk;
   logic              Rst;
   logic              ld_valid;
   logic [1:0]        ld_ch;
   logic signed [31:0] ld_val;
   logic              ld_ready;
   logic signed [31:0] dec_a;
   logic signed [31:0] dec_d;
   logic [3:0]        busy;
   logic [3:0]        done;
   logic [1:0]        cur_ch;
   logic              err;

   int n_cmp = 0;
   int n_bad = 0;

   // reference state: remaining counts, active set, slot pointer, pending pulses
   int  m_cnt [NUM_CH];
   bit [3:0] m_busy;
   bit [3:0] m_done;
   int  m_ptr;
   bit  m_run;
   bit  m_err;

   sdec_rr_scheduler #(.DATAWIDTH(32), .NUM_CH(4), .CHW(2)) dut (
      .Clk(Clk), .Rst(Rst), .ld_valid(ld_valid), .ld_ch(ld_ch), .ld_val(ld_val),
      .ld_ready(ld_ready), .dec_a(dec_a), .dec_d(dec_d), .busy(busy), .done(done),
      .cur_ch(cur_ch), .err(err)
   );

   assign dec_d = dec_a - 32'sd1;

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit m_ready();
`ifdef SDEC_SCHED_PREEMPT_EN
      return !Rst;
`else
      return !Rst && !m_busy[ld_ch];
`endif
   endfunction

   task automatic m_reset();
      for (int i = 0; i < NUM_CH; i++) m_cnt[i] = 0;
      m_busy = '0; m_done = '0; m_ptr = 0; m_run = 0; m_err = 0;
   endtask

   task automatic m_update();
      bit acc;
      bit [3:0] nb;
      bit [3:0] nd;
      int c;
      if (Rst) begin
         m_reset();
         return;
      end
      c   = int'(ld_ch);
      acc = ld_valid && m_ready();
      nb  = m_busy;
      nd  = '0;
      if (m_run && m_busy[m_ptr] && !(acc && c == m_ptr)) begin
         m_cnt[m_ptr] = m_cnt[m_ptr] - 1;
         if (m_cnt[m_ptr] == 0) begin
            nb[m_ptr] = 1'b0;
            nd[m_ptr] = 1'b1;
         end
      end
      if (acc) begin
         if (ld_val > 0) begin
            m_cnt[c] = ld_val;
            nb[c]    = 1'b1;
         end else begin
            nb[c] = 1'b0;
            if (ld_val == 0) nd[c] = 1'b1;
            else             m_err = 1'b1;
         end
      end
      m_ptr  = (m_run && nb != 0) ? (m_ptr + 1) % NUM_CH : 0;
      m_run  = (nb != 0);
      m_busy = nb;
      m_done = nd;
   endtask

   task automatic drive(input bit v, input int ch, input int val);
      ld_valid = v;
      ld_ch    = 2'(ch);
      ld_val   = val;
      @(negedge Clk);
      chk("ld_ready", ld_ready, m_ready());
      chk("dec_a", dec_a, m_cnt[m_ptr]);
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("cur_ch", cur_ch, m_ptr);
      chk("err", err, m_err);
   endtask

   task automatic step();
      m_update();
      @(posedge Clk);
      #1;
   endtask

   initial begin
      int  n1, n2, stalls;
      bit  prev3, accepted;
      m_reset();
      Rst = 1'b1; ld_valid = 1'b0; ld_ch = '0; ld_val = '0;
      @(posedge Clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         drive(0, 0, 0);
         chk("rst_ready", ld_ready, 0);
         step();
      end
      Rst = 1'b0;

      // ch0 V=3 loaded from idle: done exactly 10 cycles later
      drive(1, 0, 3);
      step();
      for (int i = 1; i <= 11; i++) begin
         drive(0, 0, 0);
         chk("lat_done0", done[0], (i == 10));
         if (i >= 10) chk("lat_busy0", busy[0], 0);
         if (i == 11) chk("lat_idle_ptr", cur_ch, 0);
         step();
      end

      // ch1 V=1 and ch2 V=2 in consecutive cycles
      drive(1, 1, 1); step();
      drive(1, 2, 2); step();
      n1 = 0; n2 = 0; prev3 = 0;
      for (int i = 0; i < 10; i++) begin
         drive(0, 0, 0);
         if (done[1] === 1'b1) n1++;
         if (done[2] === 1'b1) n2++;
         if (prev3) chk("ptr_wrap", cur_ch, 0);
         prev3 = (cur_ch === 2'd3);
         step();
      end
      chk("done1_pulses", n1, 1);
      chk("done2_pulses", n2, 1);

      // zero load pulses immediately; negative load flags err
      drive(1, 3, 0); step();
      drive(0, 0, 0);
      chk("zero_done3", done[3], 1);
      chk("zero_busy3", busy[3], 0);
      step();
      drive(0, 0, 0);
      chk("zero_done3_once", done[3], 0);
      step();
      drive(1, 0, -5); step();
      drive(0, 0, 0);
      chk("neg_err", err, 1);
      chk("neg_busy0", busy[0], 0);
      chk("neg_done", done, 0);
      step();

      // load ch0 exactly in its own slot
      drive(1, 1, 3); step();
      drive(1, 0, 2);
      chk("coll_slot", cur_ch, 0);
      step();
      for (int i = 0; i < 3; i++) begin drive(0, 0, 0); step(); end
      drive(0, 0, 0);
      chk("coll_ptr", cur_ch, 0);
      chk("coll_cnt0", dec_a, 2);
      step();
      for (int k = 0; k < 40 && m_run; k++) begin drive(0, 0, 0); step(); end
      drive(0, 0, 0);
      chk("idle_after_coll", busy, 0);
      step();

      // reload of an active channel
      drive(1, 0, 2); step();
      stalls = 0; accepted = 0;
      for (int k = 0; k < 30 && !accepted; k++) begin
         drive(1, 0, 2);
         if (ld_ready === 1'b1) accepted = 1;
         else stalls++;
         step();
      end
`ifdef SDEC_SCHED_PREEMPT_EN
      chk("reload_stalls", stalls, 0);
`else
      chk("reload_stalls", stalls, 5);
`endif
      for (int k = 0; k < 40 && m_run; k++) begin drive(0, 0, 0); step(); end

      // reset in the middle of a run with three active channels and err set
      drive(1, 0, -1); step();
      drive(1, 1, 5); step();
      drive(1, 2, 5); step();
      drive(1, 3, 5); step();
      drive(0, 0, 0); step();
      Rst = 1'b1;
      drive(0, 0, 0); step();
      Rst = 1'b0;
      drive(0, 0, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_cur_ch", cur_ch, 0);
      chk("rst_err", err, 0);
      step();

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         Rst = ($urandom_range(0, 99) == 0);
         drive($urandom_range(0, 2) == 0, int'($urandom_range(0, 3)), int'($urandom_range(0, 8)) - 2);
         step();
      end
      Rst = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
